// File: rtl/pipe_pkg.sv
// Shared types, constants and helpers for the instruction fetch pipeline.
package pipe_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned PC_STEP  = 4;
    localparam int unsigned OFF_W    = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // Signed word offset -> sign-extended byte offset; callers truncate to XLEN.
    function automatic logic [OFF_W-1:0] word_offset(input logic [15:0] imm);
        return {{(OFF_W - 18){imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pipe_fetch_unit_fifo.sv
// Prefetch queue: power-of-two circular buffer with single-cycle flush.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally left unreset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pipe_fetch_unit.sv
// Fetch unit: sequential PC generation, redirect handling and prefetch queue.
module pipe_fetch_unit
    import pipe_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_data,
    input  logic                   halt,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_base,
    input  logic [15:0]            redirect_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_instr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] target;
    logic [2*XLEN-1:0] head;
    logic            redirect;
    logic            push;
    logic            pop;

    // Redirects are meaningless before the first fetch cycle.
    assign redirect = redirect_valid && (state != ST_IDLE);
    assign pop      = out_valid && out_ready && !redirect_valid;
    assign push     = (state == ST_FETCH) && !halt && !redirect_valid
                      && ((count < CNT_W'(DEPTH)) || pop);
    assign target   = {redirect_base[XLEN-1:2], 2'b00} + XLEN'(PC_STEP)
                      + XLEN'(word_offset(redirect_imm));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        case (state)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: if (halt)  state_next = ST_HALT;
            ST_HALT:  if (!halt) state_next = ST_FETCH;
            default:  state_next = ST_IDLE;
        endcase
        if (redirect) begin
            pc_next = target;
        end else if (push) begin
            pc_next = fetch_pc + XLEN'(PC_STEP);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({fetch_pc, imem_data}),
        .rdata (head),
        .count (count)
    );

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign out_pc    = head[2*XLEN-1:XLEN];
    assign out_instr = head[XLEN-1:0];

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Scoreboard bench for pipe_fetch_unit, plus a second instance for PC wraparound.
module tb_pipe_fetch_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] PAT   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_base = '0;
    logic [15:0] redirect_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    logic [31:0] wrap_addr;
    logic [31:0] wrap_data;
    logic        wrap_valid;
    logic [31:0] wrap_pc;
    logic [31:0] wrap_instr;
    logic [2:0]  wrap_count;
    logic        wrap_halt = 1'b0;
    logic        wrap_redir = 1'b0;
    logic [31:0] wrap_base = '0;
    logic [15:0] wrap_imm = '0;
    logic        wrap_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    int          m_st;
    logic [31:0] m_pc;
    logic [63:0] sb_q[$];
    logic [31:0] wrap_exp[$];

    always #5 clk = ~clk;

    assign imem_data = imem_addr ^ PAT;
    assign wrap_data = wrap_addr ^ PAT;

    pipe_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .halt(halt), .redirect_valid(redirect_valid), .redirect_base(redirect_base),
        .redirect_imm(redirect_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .count(count)
    );

    pipe_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(wrap_addr), .imem_data(wrap_data),
        .halt(wrap_halt), .redirect_valid(wrap_redir), .redirect_base(wrap_base),
        .redirect_imm(wrap_imm), .out_valid(wrap_valid), .out_ready(wrap_ready),
        .out_pc(wrap_pc), .out_instr(wrap_instr), .count(wrap_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: compare outputs, advance the reference model, step to next negedge.
    task automatic cycle();
        logic        redir_m;
        logic        pop_m;
        logic        push_m;
        logic [31:0] off;
        check("valid", 64'(out_valid), 64'(sb_q.size() != 0));
        check("count", 64'(count), 64'(sb_q.size()));
        check("imem_addr", 64'(imem_addr), 64'(m_pc));
        if (wrap_valid && wrap_exp.size() > 0) begin
            check("wrap_pc", 64'(wrap_pc), 64'(wrap_exp[0]));
            check("wrap_instr", 64'(wrap_instr), 64'(wrap_exp[0] ^ PAT));
            void'(wrap_exp.pop_front());
        end
        redir_m = redirect_valid && (m_st != 0);
        pop_m   = (sb_q.size() != 0) && out_ready && !redirect_valid;
        push_m  = (m_st == 1) && !halt && !redirect_valid
                  && ((sb_q.size() < DEPTH) || pop_m);
        if (pop_m) begin
            check("head_pc", 64'(out_pc), 64'(sb_q[0][63:32]));
            check("head_instr", 64'(out_instr), 64'(sb_q[0][31:0]));
            void'(sb_q.pop_front());
        end
        if (redir_m) begin
            sb_q.delete();
            off  = {{16{redirect_imm[15]}}, redirect_imm};
            m_pc = (redirect_base & 32'hFFFF_FFFC) + 32'd4 + (off << 2);
        end else if (push_m) begin
            sb_q.push_back({m_pc, m_pc ^ PAT});
            m_pc = m_pc + 32'd4;
        end
        case (m_st)
            0:       m_st = 1;
            1:       if (halt) m_st = 2;
            default: if (!halt) m_st = 1;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_addr", 64'(imem_addr), 64'(0));
        check("rst_wrap_addr", 64'(wrap_addr), 64'(32'hFFFF_FFF8));
        sb_q.delete();
        m_st = 0;
        m_pc = 32'h0;
        wrap_exp = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        @(posedge clk);
        @(negedge clk);
        halt = 1'b0;
        redirect_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Streaming with decode always ready
        out_ready = 1'b1;
        repeat (8) cycle();

        // Backpressure fills the queue, then full push+pop
        do_reset();
        out_ready = 1'b0;
        repeat (10) cycle();
        check("full_count", 64'(count), 64'(4));
        check("full_pc", 64'(imem_addr), 64'(32'h10));
        check("first_pop_pc", 64'(out_pc), 64'(0));
        out_ready = 1'b1;
        repeat (4) cycle();

        // Backward redirect with three entries queued
        do_reset();
        out_ready = 1'b0;
        repeat (4) cycle();
        check("pre_redir_count", 64'(count), 64'(3));
        redirect_valid = 1'b1;
        redirect_base  = 32'h20;
        redirect_imm   = 16'hFFFE;
        cycle();
        redirect_valid = 1'b0;
        check("flush_count", 64'(count), 64'(0));
        check("flush_valid", 64'(out_valid), 64'(0));
        check("redir_pc", 64'(imem_addr), 64'(32'h1C));
        out_ready = 1'b1;
        cycle();
        check("redir_head", 64'(out_pc), 64'(32'h1C));
        repeat (2) cycle();

        // Halt at count 2: drain, hold PC, resume
        do_reset();
        out_ready = 1'b0;
        repeat (3) cycle();
        check("halt_count", 64'(count), 64'(2));
        halt = 1'b1;
        out_ready = 1'b1;
        repeat (4) cycle();
        check("halt_drained", 64'(count), 64'(0));
        check("halt_pc", 64'(imem_addr), 64'(32'h8));
        halt = 1'b0;
        repeat (3) cycle();

        // Redirect while halted, then resume at target
        halt = 1'b1;
        repeat (2) cycle();
        redirect_valid = 1'b1;
        redirect_base  = 32'h103;
        redirect_imm   = 16'h0003;
        cycle();
        redirect_valid = 1'b0;
        check("halt_redir_pc", 64'(imem_addr), 64'(32'h110));
        repeat (2) cycle();
        halt = 1'b0;
        repeat (4) cycle();

        // Redirect during the idle cycle is ignored
        do_reset();
        redirect_valid = 1'b1;
        redirect_base  = 32'h40;
        redirect_imm   = 16'h0001;
        cycle();
        redirect_valid = 1'b0;
        check("idle_redir_pc", 64'(imem_addr), 64'(0));
        repeat (3) cycle();

        // Asynchronous reset while full
        out_ready = 1'b0;
        repeat (6) cycle();
        check("prereset_full", 64'(count), 64'(4));
        do_reset();
        out_ready = 1'b1;
        repeat (4) cycle();

        // Random mix of backpressure, halts and redirects
        repeat (300) begin
            out_ready      = 1'($urandom_range(0, 1));
            halt           = ($urandom_range(0, 7) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_base  = $urandom;
            redirect_imm   = 16'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
